fb_access_arbiter: RTL and testbench

- Shares the single-port pixel memory behind the image storage between two users: the display fetch path and a host writer.
- Display reads have absolute priority and are served every cycle they are requested, so the VGA pipeline never stalls.
- Host writes are buffered in a small FIFO and retire only on cycles with no read.
- A clear sequencer fills the whole memory with one colour, again using only idle cycles.

---
 rtl/fb_access_arbiter_if.sv | 40 ++++
 rtl/fb_access_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_access_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_access_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its two users and the pixel memory.
interface fb_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LVL_W  = 3
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              clr_req;
    logic [DATA_W-1:0] clr_color;
    logic              busy;
    logic              clr_done;
    logic [LVL_W-1:0]  fifo_level;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_req, clr_color, mem_rdata,
        output rd_data, rd_valid, wr_ready, busy, clr_done, fifo_level,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_req, clr_color, mem_rdata,
        input  rd_data, rd_valid, wr_ready, busy, clr_done, fifo_level,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port pixel memory arbiter: display reads always win, buffered host
// writes and a full-memory colour clear only use cycles with no read.
module fb_access_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_DEPTH  = 190,
    parameter int FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    fb_access_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  ONE_LVL   = LVL_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level, drain_cnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_color;
    logic [DATA_W-1:0] rd_hold;
    logic              rd_valid_q, clr_done_q;
    logic              rd_grant, push, pop, clr_wr, clr_last, accept_clr, wr_ready;

    // Per-cycle grant: a read request pre-empts every FIFO pop and clear write.
    always_comb begin
        rd_grant   = bus.rd_req && !rst;
        wr_ready   = !rst && (level < FULL_LVL);
        push       = bus.wr_valid && wr_ready;
        accept_clr = !rst && (state == IDLE) && bus.clr_req;
        pop        = 1'b0;
        clr_wr     = 1'b0;
        if (!rst && !bus.rd_req) begin
            case (state)
                IDLE:    pop = (level != '0);
                DRAIN:   pop = (drain_cnt != '0) && (level != '0);
                CLEAR:   clr_wr = 1'b1;
                default: pop = 1'b0;
            endcase
        end
        clr_last = clr_wr && (clr_addr == LAST_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_clr) state_next = DRAIN;
            end
            DRAIN: begin
                if ((drain_cnt == '0) || ((drain_cnt == ONE_LVL) && pop)) state_next = CLEAR;
            end
            CLEAR: begin
                if (clr_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rd_grant) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.rd_addr;
        end else if (pop) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = fifo_addr[rd_ptr];
            bus.mem_wdata = fifo_data[rd_ptr];
        end else if (clr_wr) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = clr_addr;
            bus.mem_wdata = clr_color;
        end
        bus.busy       = (state != IDLE);
        bus.wr_ready   = wr_ready;
        bus.fifo_level = level;
        bus.clr_done   = clr_done_q;
        bus.rd_valid   = rd_valid_q;
        bus.rd_data    = rd_valid_q ? bus.mem_rdata : rd_hold;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
        end
    end

    // Only entries already queued (after this cycle's pop) are drained ahead of the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
            clr_addr  <= '0;
            clr_color <= '0;
        end else if (accept_clr) begin
            drain_cnt <= level - (pop ? ONE_LVL : '0);
            clr_addr  <= '0;
            clr_color <= bus.clr_color;
        end else begin
            if ((state == DRAIN) && pop) drain_cnt <= drain_cnt - ONE_LVL;
            if (clr_wr && !clr_last)     clr_addr  <= clr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_hold    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_grant;
            clr_done_q <= clr_last;
            if (rd_valid_q) rd_hold <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed self-checking bench for fb_access_arbiter with a synchronous memory model.
module tb_fb_access_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int MEM_DEPTH = 190;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_rec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   conflict_cnt = 0;
    int   done_cnt = 0;
    wr_rec_t wr_log[$];
    logic [7:0] mem [256] = '{5: 8'h11, 6: 8'h22, 7: 8'h33, default: 8'h00};

    always #5 clk = ~clk;

    fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(3)) bus();

    fb_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Single-port memory with one-cycle read latency; also logs every write.
    always @(posedge clk) begin
        if (!rst && bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
                wr_log.push_back({bus.mem_addr, bus.mem_wdata});
                if (bus.rd_req) conflict_cnt++;
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (bus.clr_done) done_cnt++;
    end

    task automatic idle_inputs();
        bus.rd_req = 1'b0;   bus.rd_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_req = 1'b0;  bus.clr_color = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_addr = 8'h05;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (bus.mem_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        tests++; if (bus.mem_addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", bus.mem_addr); end
        tests++; if (bus.mem_wdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_mem_wdata: got %h expected 00", bus.mem_wdata); end
        tests++; if (bus.rd_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.clr_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_clr_done: got %b expected 0", bus.clr_done); end
        tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
        tests++; if (bus.fifo_level !== 3'd0) begin fails++; $display("[TB] FAIL reset_fifo_level: got %0d expected 0", bus.fifo_level); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        tests++; if (bus.wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL release_wr_ready: got %b expected 1", bus.wr_ready); end
    endtask

    task automatic test_read_burst();
        logic [7:0] exp_rd [3];
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rd_req = (i < 3);
            bus.rd_addr = 8'(5 + i);
            #1;
            if (i < 3) begin
                tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'(5 + i)) begin
                    fails++; $display("[TB] FAIL read_grant%0d: got en=%b we=%b addr=%h expected en=1 we=0 addr=%h", i, bus.mem_en, bus.mem_we, bus.mem_addr, 8'(5 + i));
                end
            end
            if (i > 0) begin
                tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rd[i-1]) begin
                    fails++; $display("[TB] FAIL read_data%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.rd_valid, bus.rd_data, exp_rd[i-1]);
                end
            end
        end
        @(negedge clk);
        #1;
        tests++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h33) begin
            fails++; $display("[TB] FAIL read_hold: got valid=%b data=%h expected valid=0 data=33", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_fifo_fill();
        int base;
        int bad;
        base = wr_log.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b1; bus.rd_addr = 8'h05;
            bus.wr_valid = 1'b1; bus.wr_addr = 8'(i); bus.wr_data = 8'(8'hA0 + i);
            #1;
            tests++; if (bus.wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready%0d: got %b expected 1", i, bus.wr_ready); end
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1;
        tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_wr_ready: got %b expected 0", bus.wr_ready); end
        tests++; if (bus.fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL full_level: got %0d expected 4", bus.fifo_level); end
        tests++; if (wr_log.size() - base != 0) begin fails++; $display("[TB] FAIL full_no_write: got %0d writes expected 0", wr_log.size() - base); end
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1;
        tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'hA0) begin
            fails++; $display("[TB] FAIL retire_head: got we=%b addr=%h data=%h expected we=1 addr=00 data=a0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        repeat (4) @(negedge clk);
        #1;
        tests++; if (bus.fifo_level !== 3'd0 || bus.wr_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL drained_level: got level=%0d ready=%b expected level=0 ready=1", bus.fifo_level, bus.wr_ready);
        end
        tests++; if (wr_log.size() - base != 4) begin fails++; $display("[TB] FAIL retire_count: got %0d expected 4", wr_log.size() - base); end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[i] !== 8'(8'hA0 + i)) bad++;
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL retire_mem: got %0d wrong cells expected 0", bad); end
    endtask

    task automatic test_alternate();
        logic       prev_rd;
        logic [7:0] prev_data;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] rd_table [3];
        rd_table[0] = 8'h11; rd_table[1] = 8'h22; rd_table[2] = 8'h33;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b1; bus.rd_addr = 8'h05;
            bus.wr_valid = 1'b1; bus.wr_addr = 8'(10 + i); bus.wr_data = 8'(8'h5A + i);
        end
        prev_rd = 1'b1;
        prev_data = 8'h11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.wr_valid = 1'b0;
            bus.rd_req = (i % 2 == 0);
            bus.rd_addr = 8'(5 + i / 2);
            exp_we = (i == 1) || (i == 3);
            exp_addr = (i == 1) ? 8'd10 : 8'd11;
            #1;
            tests++; if (bus.rd_valid !== prev_rd) begin fails++; $display("[TB] FAIL alt_valid%0d: got %b expected %b", i, bus.rd_valid, prev_rd); end
            if (prev_rd) begin
                tests++; if (bus.rd_data !== prev_data) begin fails++; $display("[TB] FAIL alt_data%0d: got %h expected %h", i, bus.rd_data, prev_data); end
            end
            tests++; if (bus.mem_we !== exp_we) begin fails++; $display("[TB] FAIL alt_we%0d: got %b expected %b", i, bus.mem_we, exp_we); end
            if (exp_we) begin
                tests++; if (bus.mem_addr !== exp_addr) begin fails++; $display("[TB] FAIL alt_addr%0d: got %h expected %h", i, bus.mem_addr, exp_addr); end
            end
            prev_rd = bus.rd_req;
            prev_data = rd_table[i / 2];
        end
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1;
        tests++; if (bus.fifo_level !== 3'd0 || mem[10] !== 8'h5A || mem[11] !== 8'h5B) begin
            fails++; $display("[TB] FAIL alt_result: got level=%0d m10=%h m11=%h expected 0 5a 5b", bus.fifo_level, mem[10], mem[11]);
        end
    endtask

    task automatic test_clear();
        int  base;
        int  done0;
        int  bad;
        bit  seen;
        base = wr_log.size();
        done0 = done_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b1; bus.rd_addr = 8'h05;
            bus.wr_valid = 1'b1; bus.wr_addr = 8'(20 + i); bus.wr_data = 8'(8'h41 + i);
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.clr_req = 1'b1; bus.clr_color = 8'hE0;
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL clr_busy_before: got %b expected 0", bus.busy); end
        @(negedge clk);
        bus.clr_req = 1'b0; bus.clr_color = 8'h00; bus.rd_req = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 8'd7; bus.wr_data = 8'h1C;
        #1;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL clr_busy: got %b expected 1", bus.busy); end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (bus.clr_done) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("[TB] FAIL clr_done_timeout: got no pulse expected one within 400 cycles"); end
        repeat (3) @(negedge clk);
        #1;
        tests++; if (wr_log.size() - base != 193) begin fails++; $display("[TB] FAIL clr_write_count: got %0d expected 193", wr_log.size() - base); end
        bad = 0;
        if (wr_log.size() - base == 193) begin
            if (wr_log[base] !== {8'd20, 8'h41}) bad++;
            if (wr_log[base + 1] !== {8'd21, 8'h42}) bad++;
            for (int k = 0; k < MEM_DEPTH; k++) if (wr_log[base + 2 + k] !== {8'(k), 8'hE0}) bad++;
            if (wr_log[base + 192] !== {8'd7, 8'h1C}) bad++;
        end else begin
            bad = 1;
        end
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL clr_write_order: got %0d out-of-order writes expected 0", bad); end
        tests++; if (done_cnt - done0 != 1) begin fails++; $display("[TB] FAIL clr_done_count: got %0d expected 1", done_cnt - done0); end
        tests++; if (bus.busy !== 1'b0 || bus.fifo_level !== 3'd0) begin
            fails++; $display("[TB] FAIL clr_end_state: got busy=%b level=%0d expected 0 0", bus.busy, bus.fifo_level);
        end
        bad = 0;
        for (int k = 0; k < MEM_DEPTH; k++) if (mem[k] !== ((k == 7) ? 8'h1C : 8'hE0)) bad++;
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL clr_mem: got %0d wrong cells expected 0", bad); end
    endtask

    task automatic test_reset_mid_clear();
        int  done0;
        int  log0;
        bit  hit;
        done0 = done_cnt;
        @(negedge clk);
        bus.clr_req = 1'b1; bus.clr_color = 8'h77;
        @(negedge clk);
        bus.clr_req = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 8'd30; bus.wr_data = 8'h61;
        @(negedge clk);
        bus.wr_addr = 8'd31; bus.wr_data = 8'h62;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (bus.mem_we && bus.mem_addr == 8'd50) hit = 1'b1;
        end
        tests++; if (!hit) begin fails++; $display("[TB] FAIL mid_clear_reach: got no write to 50 expected one within 300 cycles"); end
        tests++; if (bus.fifo_level !== 3'd2) begin fails++; $display("[TB] FAIL mid_clear_queued: got %0d expected 2", bus.fifo_level); end
        rst = 1'b1;
        #1;
        tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_reset_outputs: got en=%b we=%b busy=%b expected 0 0 0", bus.mem_en, bus.mem_we, bus.busy);
        end
        tests++; if (bus.fifo_level !== 3'd0 || bus.wr_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_reset_fifo: got level=%0d ready=%b expected 0 0", bus.fifo_level, bus.wr_ready);
        end
        log0 = wr_log.size();
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        tests++; if (done_cnt != done0) begin fails++; $display("[TB] FAIL mid_reset_done: got %0d pulses expected 0", done_cnt - done0); end
        tests++; if (wr_log.size() != log0 || bus.busy !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_reset_quiet: got %0d writes busy=%b expected 0 0", wr_log.size() - log0, bus.busy);
        end
        tests++; if (mem[49] !== 8'h77 || mem[50] !== 8'hE0 || mem[30] !== 8'h77 || mem[31] !== 8'h77) begin
            fails++; $display("[TB] FAIL mid_reset_mem: got m49=%h m50=%h m30=%h m31=%h expected 77 e0 77 77", mem[49], mem[50], mem[30], mem[31]);
        end
    endtask

    task automatic test_clear_ignored();
        int  base;
        int  done0;
        int  bad;
        bit  seen;
        base = wr_log.size();
        done0 = done_cnt;
        @(negedge clk);
        bus.clr_req = 1'b1; bus.clr_color = 8'h3C;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (20) @(negedge clk);
        bus.clr_req = 1'b1; bus.clr_color = 8'h99;
        #1;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL ign_busy: got %b expected 1", bus.busy); end
        @(negedge clk);
        bus.clr_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (bus.clr_done) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("[TB] FAIL ign_done_timeout: got no pulse expected one within 400 cycles"); end
        repeat (5) @(negedge clk);
        #1;
        tests++; if (wr_log.size() - base != MEM_DEPTH) begin fails++; $display("[TB] FAIL ign_write_count: got %0d expected %0d", wr_log.size() - base, MEM_DEPTH); end
        tests++; if (done_cnt - done0 != 1) begin fails++; $display("[TB] FAIL ign_done_count: got %0d expected 1", done_cnt - done0); end
        bad = 0;
        for (int k = 0; k < MEM_DEPTH; k++) if (mem[k] !== 8'h3C) bad++;
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL ign_mem: got %0d wrong cells expected 0", bad); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL ign_end_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_exclusive();
        tests++; if (conflict_cnt != 0) begin fails++; $display("[TB] FAIL write_during_read: got %0d expected 0", conflict_cnt); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_read_burst();
        test_fifo_fill();
        test_alternate();
        test_clear();
        test_reset_mid_clear();
        test_clear_ignored();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
